// File: rtl/meta_combiner_pkg.sv
// Shared encodings and default widths for the stacking meta classifier.
package meta_combiner_pkg;

    localparam int unsigned DEF_NUM_BASE  = 3;
    localparam int unsigned DEF_W_WIDTH   = 9;
    localparam int unsigned DEF_ACC_WIDTH = 14;

    typedef enum logic [3:0] {
        COLLECT = 4'b0001,
        ACCUM   = 4'b0010,
        BIAS    = 4'b0100,
        FINISH  = 4'b1000
    } state_e;

    localparam logic [1:0] RES_POS = 2'b01;
    localparam logic [1:0] RES_NEG = 2'b11;

endpackage

// File: rtl/meta_combiner_if.sv
// Vote, weight-programming and decision signals of the meta classifier.
interface meta_combiner_if
    import meta_combiner_pkg::*;
#(
    parameter int unsigned NUM_BASE = DEF_NUM_BASE,
    parameter int unsigned W_WIDTH  = DEF_W_WIDTH
);
    localparam int unsigned ADDR_W = $clog2(NUM_BASE + 1);

    logic [2*NUM_BASE-1:0]      base_result;
    logic [NUM_BASE-1:0]        base_ready;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic signed [W_WIDTH-1:0]  wr_data;
    logic [1:0]                 result;
    logic                       ready;
    logic                       busy;
    logic                       overrun;

    modport master (
        output base_result, base_ready, wr_en, wr_addr, wr_data,
        input  result, ready, busy, overrun
    );

    modport slave (
        input  base_result, base_ready, wr_en, wr_addr, wr_data,
        output result, ready, busy, overrun
    );

endinterface

// File: rtl/meta_weight_bank.sv
// Meta weights plus bias: synchronous write (blocked while busy), combinational read.
module meta_weight_bank
    import meta_combiner_pkg::*;
#(
    parameter  int unsigned NUM_BASE = DEF_NUM_BASE,
    parameter  int unsigned W_WIDTH  = DEF_W_WIDTH,
    localparam int unsigned ADDR_W   = $clog2(NUM_BASE + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic signed [W_WIDTH-1:0] wr_data,
    input  logic                      busy,
    input  logic [ADDR_W-1:0]         rd_idx,
    output logic signed [W_WIDTH-1:0] weight_rd_c,
    output logic signed [W_WIDTH-1:0] bias_rd_c
);

    logic signed [W_WIDTH-1:0] weight_q [NUM_BASE];
    logic signed [W_WIDTH-1:0] weight_d [NUM_BASE];
    logic signed [W_WIDTH-1:0] bias_q, bias_d;
    logic                      wr_ok_c;

    // Addresses above NUM_BASE match nothing and are dropped.
    always_comb begin
        wr_ok_c  = wr_en && !busy;
        weight_d = weight_q;
        bias_d   = bias_q;
        if (wr_ok_c) begin
            if (wr_addr == ADDR_W'(NUM_BASE)) begin
                bias_d = wr_data;
            end
            for (int k = 0; k < NUM_BASE; k++) begin
                if (wr_addr == ADDR_W'(k)) begin
                    weight_d[k] = wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_BASE; k++) begin
                weight_q[k] <= '0;
            end
            bias_q <= '0;
        end else begin
            weight_q <= weight_d;
            bias_q   <= bias_d;
        end
    end

    always_comb begin
        weight_rd_c = '0;
        for (int k = 0; k < NUM_BASE; k++) begin
            if (rd_idx == ADDR_W'(k)) begin
                weight_rd_c = weight_q[k];
            end
        end
    end

    assign bias_rd_c = bias_q;

endmodule

// File: rtl/meta_combiner.sv
// Meta classifier: collects base votes, serially accumulates weighted votes
// plus bias, and emits a +1/-1 decision with a one-cycle ready pulse.
module meta_combiner
    import meta_combiner_pkg::*;
#(
    parameter int unsigned NUM_BASE  = DEF_NUM_BASE,
    parameter int unsigned W_WIDTH   = DEF_W_WIDTH,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
    input logic            clk,
    input logic            rst,
    meta_combiner_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(NUM_BASE + 1);
    localparam int unsigned EXT_W  = ACC_WIDTH - W_WIDTH;

    state_e                      state_q, state_d;
    logic [1:0]                  vote_q [NUM_BASE];
    logic [1:0]                  vote_d [NUM_BASE];
    logic [NUM_BASE-1:0]         flags_q, flags_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0]           idx_q, idx_d;
    logic [1:0]                  result_q, result_d;
    logic                        ready_q, ready_d;
    logic                        busy_q, busy_d;
    logic                        overrun_q, overrun_d;

    logic                        busy_c;
    logic signed [W_WIDTH-1:0]   weight_rd_c, bias_rd_c;
    logic [1:0]                  vote_sel_c;
    logic signed [ACC_WIDTH-1:0] w_ext_c, b_ext_c, term_c;

    assign busy_c = (state_q != COLLECT);

    meta_weight_bank #(
        .NUM_BASE (NUM_BASE),
        .W_WIDTH  (W_WIDTH)
    ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (bus.wr_en),
        .wr_addr     (bus.wr_addr),
        .wr_data     (bus.wr_data),
        .busy        (busy_c),
        .rd_idx      (idx_q),
        .weight_rd_c (weight_rd_c),
        .bias_rd_c   (bias_rd_c)
    );

    // Signed 2-bit vote times weight; -2 is the only case needing a shift.
    always_comb begin
        vote_sel_c = 2'b00;
        for (int k = 0; k < NUM_BASE; k++) begin
            if (idx_q == ADDR_W'(k)) begin
                vote_sel_c = vote_q[k];
            end
        end
        w_ext_c = {{EXT_W{weight_rd_c[W_WIDTH-1]}}, weight_rd_c};
        b_ext_c = {{EXT_W{bias_rd_c[W_WIDTH-1]}}, bias_rd_c};
        case (vote_sel_c)
            2'b01:   term_c = w_ext_c;
            2'b11:   term_c = -w_ext_c;
            2'b10:   term_c = -(w_ext_c <<< 1);
            default: term_c = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        vote_d    = vote_q;
        flags_d   = flags_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        result_d  = result_q;
        ready_d   = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            COLLECT: begin
                for (int k = 0; k < NUM_BASE; k++) begin
                    if (bus.base_ready[k]) begin
                        vote_d[k] = bus.base_result[2*k +: 2];
                    end
                end
                flags_d = flags_q | bus.base_ready;
                if (&(flags_q | bus.base_ready)) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            end
            ACCUM: begin
                acc_d = acc_q + term_c;
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(NUM_BASE - 1)) begin
                    state_d = BIAS;
                end
            end
            BIAS: begin
                acc_d   = acc_q + b_ext_c;
                state_d = FINISH;
            end
            FINISH: begin
                result_d = acc_q[ACC_WIDTH-1] ? RES_NEG : RES_POS;
                ready_d  = 1'b1;
                flags_d  = '0;
                state_d  = COLLECT;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        // Any strobe outside COLLECT is a dropped vote.
        if (busy_c && (|bus.base_ready)) begin
            overrun_d = 1'b1;
        end
        busy_d = (state_d != COLLECT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= COLLECT;
            for (int k = 0; k < NUM_BASE; k++) begin
                vote_q[k] <= 2'b00;
            end
            flags_q   <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            result_q  <= 2'b00;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vote_q    <= vote_d;
            flags_q   <= flags_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.result  = result_q;
    assign bus.ready   = ready_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_meta_combiner.sv
// Self-checking bench for meta_combiner: vector table plus hand-written
// multi-cycle sequences, with a ready-driven scoreboard for decisions.
module tb_meta_combiner;
    import meta_combiner_pkg::*;

    localparam int unsigned NB  = 3;
    localparam int unsigned WW  = 9;
    localparam int unsigned AW  = 14;
    localparam int unsigned ADW = $clog2(NB + 1);
    localparam int          NVEC = 7;

    typedef struct {
        int         w0, w1, w2, bias;
        int         v0, v1, v2;
        logic [1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    meta_combiner_if #(.NUM_BASE(NB), .W_WIDTH(WW)) bus ();

    meta_combiner #(.NUM_BASE(NB), .W_WIDTH(WW), .ACC_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] pack3(input int a, input int b, input int c);
        pack3 = {2'(c), 2'(b), 2'(a)};
    endfunction

    task automatic wr(input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADW'(addr);
        bus.wr_data = WW'(data);
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic program_w(input int w0, input int w1, input int w2, input int b);
        wr(0, w0);
        wr(1, w1);
        wr(2, w2);
        wr(3, b);
    endtask

    // One strobe cycle; also releases any write driven alongside it.
    task automatic strobe(input logic [NB-1:0] mask, input logic [5:0] votes);
        bus.base_ready  = mask;
        bus.base_result = votes;
        tick();
        bus.base_ready  = '0;
        bus.base_result = '0;
        bus.wr_en       = 1'b0;
    endtask

    // Waits (bounded) for ready; lat counts edges since the completing strobe.
    task automatic wait_ready(input string tag, input int start);
        int lat;
        lat = start;
        while (!bus.ready && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd5);
        tick();
        check({tag, " ready_pulse"}, 32'(bus.ready), 32'd0);
    endtask

    // Scoreboard: every ready pops one expected decision.
    initial begin
        logic [1:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (rst && bus.ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready: got ready=1 result=%0d expected no ready", bus.result);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(bus.result), 32'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[NVEC];

        tbl[0] = '{w0: 5,   w1: -3,   w2: 2,   bias: -1,   v0: 1,  v1: 1,  v2: -1, exp: RES_NEG};
        tbl[1] = '{w0: 5,   w1: -3,   w2: 2,   bias: 0,    v0: 1,  v1: 1,  v2: -1, exp: RES_POS};
        tbl[2] = '{w0: 255, w1: 255,  w2: 255, bias: -256, v0: -1, v1: -1, v2: -1, exp: RES_NEG};
        tbl[3] = '{w0: 255, w1: 255,  w2: 255, bias: -256, v0: 1,  v1: 1,  v2: 1,  exp: RES_POS};
        tbl[4] = '{w0: 5,   w1: -3,   w2: 2,   bias: -1,   v0: -2, v1: 0,  v2: 1,  exp: RES_NEG};
        tbl[5] = '{w0: 5,   w1: -3,   w2: 2,   bias: -1,   v0: 0,  v1: -1, v2: 0,  exp: RES_POS};
        tbl[6] = '{w0: -256,w1: -256, w2: -256,bias: -256, v0: -2, v1: -2, v2: -2, exp: RES_POS};

        rst             = 1'b0;
        bus.base_ready  = '0;
        bus.base_result = '0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        tick();
        tick();
        check("rst result", 32'(bus.result), 32'd0);
        check("rst ready", 32'(bus.ready), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst overrun", 32'(bus.overrun), 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            program_w(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].bias);
            exp_q.push_back(tbl[i].exp);
            strobe(3'b111, pack3(tbl[i].v0, tbl[i].v1, tbl[i].v2));
            check($sformatf("vec%0d busy", i), 32'(bus.busy), 32'd1);
            wait_ready($sformatf("vec%0d", i), 0);
        end

        // Staggered votes with slot 0 overwritten (last wins): 5-3+2-1 = 3.
        program_w(5, -3, 2, -1);
        exp_q.push_back(RES_POS);
        strobe(3'b001, pack3(-1, 0, 0));
        tick();
        strobe(3'b001, pack3(1, 0, 0));
        tick();
        strobe(3'b010, pack3(0, 1, 0));
        for (int i = 0; i < 4; i++) tick();
        check("stagger busy_before_last", 32'(bus.busy), 32'd0);
        strobe(3'b100, pack3(0, 0, 1));
        wait_ready("stagger", 0);

        // Write coinciding with the completing strobe is used: 5-3+7-1 = 8.
        program_w(5, -3, 2, -1);
        exp_q.push_back(RES_POS);
        strobe(3'b011, pack3(1, 1, 0));
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADW'(2);
        bus.wr_data = WW'(-7);
        strobe(3'b100, pack3(0, 0, -1));
        wait_ready("same_cycle_wr", 0);

        // Strobe and weight write while busy are both dropped: 5-3-2-1 = -1.
        program_w(5, -3, 2, -1);
        exp_q.push_back(RES_NEG);
        strobe(3'b111, pack3(1, 1, -1));
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADW'(2);
        bus.wr_data = WW'(-100);
        strobe(3'b111, pack3(1, 1, 1));
        check("drop overrun", 32'(bus.overrun), 32'd1);
        wait_ready("drop", 1);
        // Weight 2 must still be 2: 5-3+2-1 = 3.
        exp_q.push_back(RES_POS);
        strobe(3'b111, pack3(1, 1, 1));
        wait_ready("after_drop", 0);
        check("overrun sticky", 32'(bus.overrun), 32'd1);

        // Reset during ACCUM aborts the round and clears the weights.
        strobe(3'b111, pack3(1, 1, -1));
        rst = 1'b0;
        tick();
        check("abort result", 32'(bus.result), 32'd0);
        check("abort ready", 32'(bus.ready), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort overrun", 32'(bus.overrun), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        // All weights zero now, so sum is 0 -> +1.
        exp_q.push_back(RES_POS);
        strobe(3'b111, pack3(-1, -1, -1));
        wait_ready("cleared_weights", 0);
        program_w(5, -3, 2, -1);
        exp_q.push_back(RES_NEG);
        strobe(3'b111, pack3(1, 1, -1));
        wait_ready("reprogrammed", 0);

        tick();
        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
